// File: rtl/score_keeper.sv
// score_keeper: frame-tick driven game score with BCD digits, high score and IDLE/PLAY/OVER control.
module score_keeper #(
  parameter int FRAMES_PER_POINT = 8,
  parameter int MAX_SCORE        = 99
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_frame_tick,
  input  logic       i_move,
  input  logic       i_collision,
  input  logic       i_start,
  output logic [6:0] o_score,
  output logic [3:0] o_score_tens,
  output logic [3:0] o_score_ones,
  output logic [6:0] o_high_score,
  output logic [1:0] o_state,
  output logic       o_new_high
);
  typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, OVER = 2'b10} state_t;
  localparam logic [7:0] HOLD_LAST = 8'(FRAMES_PER_POINT - 1);
  localparam logic [6:0] SCORE_MAX = 7'(MAX_SCORE);
  state_t     state, state_n;
  logic [6:0] score, score_n, high, high_n;
  logic [3:0] tens, tens_n, ones, ones_n;
  logic [7:0] hold, hold_n;
  logic       new_high, new_high_n;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      score    <= '0;
      tens     <= '0;
      ones     <= '0;
      hold     <= '0;
      high     <= '0;
      new_high <= 1'b0;
    end else begin
      state    <= state_n;
      score    <= score_n;
      tens     <= tens_n;
      ones     <= ones_n;
      hold     <= hold_n;
      high     <= high_n;
      new_high <= new_high_n;
    end
  end
  always_comb begin
    state_n    = state;
    score_n    = score;
    tens_n     = tens;
    ones_n     = ones;
    hold_n     = hold;
    high_n     = high;
    new_high_n = new_high;
    case (state)
      IDLE: begin
        score_n = '0;
        tens_n  = '0;
        ones_n  = '0;
        hold_n  = '0;
        state_n = i_start ? PLAY : IDLE;
      end
      PLAY: begin
        if (i_collision) begin
          state_n    = OVER;
          new_high_n = score > high;
          high_n     = (score > high) ? score : high;
        end else if (i_frame_tick) begin
          // releasing the button restarts accumulation toward the next point
          hold_n = (!i_move || hold == HOLD_LAST) ? 8'd0 : hold + 8'd1;
          if (i_move && hold == HOLD_LAST && score != SCORE_MAX) begin
            score_n = score + 7'd1;
            tens_n  = (ones == 4'd9) ? tens + 4'd1 : tens;
            ones_n  = (ones == 4'd9) ? 4'd0 : ones + 4'd1;
          end
        end
      end
      OVER: begin
        if (i_start) begin
          state_n    = PLAY;
          score_n    = '0;
          tens_n     = '0;
          ones_n     = '0;
          hold_n     = '0;
          new_high_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  assign o_score      = score;
  assign o_score_tens = tens;
  assign o_score_ones = ones;
  assign o_high_score = high;
  assign o_state      = state;
  assign o_new_high   = new_high;
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: scenario tasks for score_keeper with a queue of expected output snapshots.
module tb_score_keeper;
  localparam int FPP = 8;
  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_frame_tick = 1'b0;
  logic       i_move = 1'b0;
  logic       i_collision = 1'b0;
  logic       i_start = 1'b0;
  logic [6:0] o_score, o_high_score;
  logic [3:0] o_score_tens, o_score_ones;
  logic [1:0] o_state;
  logic       o_new_high;
  int         passed = 0;
  int         total = 0;
  logic [24:0] sb[$];
  logic [24:0] exp_v;
  wire  [24:0] obs = {o_state, o_score, o_score_tens, o_score_ones, o_high_score, o_new_high};

  score_keeper #(.FRAMES_PER_POINT(FPP), .MAX_SCORE(99)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_frame_tick(i_frame_tick), .i_move(i_move),
    .i_collision(i_collision), .i_start(i_start), .o_score(o_score),
    .o_score_tens(o_score_tens), .o_score_ones(o_score_ones), .o_high_score(o_high_score),
    .o_state(o_state), .o_new_high(o_new_high)
  );

  always #5 i_clk = ~i_clk;

  // layout: state, score, tens, ones, high, new_high
  function automatic logic [24:0] pack(input logic [1:0] st, input int sc, input int hi, input logic nh);
    return {st, 7'(sc), 4'(sc / 10), 4'(sc % 10), 7'(hi), nh};
  endfunction

  task automatic cyc(input logic ft, input logic mv, input logic col, input logic st);
    i_frame_tick = ft; i_move = mv; i_collision = col; i_start = st;
    @(negedge i_clk);
    i_frame_tick = 0; i_move = 0; i_collision = 0; i_start = 0;
  endtask

  task automatic play_points(input int n);
    repeat (n * FPP) cyc(1, 1, 0, 0);
  endtask

  task automatic do_reset();
    i_rst_n = 0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1;
  endtask

  task automatic test_reset();
    sb.push_back(pack(2'b00, 0, 0, 0));
    do_reset();
    exp_v = sb.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL reset_state got %h exp %h", obs, exp_v); else passed++;
    sb.push_back(pack(2'b00, 0, 0, 0));
    repeat (12) cyc(1, 1, 1, 0);
    exp_v = sb.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL idle_hold got %h exp %h", obs, exp_v); else passed++;
  endtask

  task automatic test_count();
    sb.push_back(pack(2'b01, 0, 0, 0));
    cyc(0, 0, 0, 1);
    exp_v = sb.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL start_play got %h exp %h", obs, exp_v); else passed++;
    sb.push_back(pack(2'b01, 1, 0, 0));
    repeat (2 * FPP - 1) cyc(1, 1, 0, 0);
    exp_v = sb.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL count_15 got %h exp %h", obs, exp_v); else passed++;
    sb.push_back(pack(2'b01, 2, 0, 0));
    cyc(1, 1, 0, 0);
    exp_v = sb.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL count_16 got %h exp %h", obs, exp_v); else passed++;
    sb.push_back(pack(2'b01, 2, 0, 0));
    repeat (20) cyc(0, 1, 0, 0);
    exp_v = sb.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL move_no_tick got %h exp %h", obs, exp_v); else passed++;
  endtask

  task automatic test_release();
    do_reset();
    cyc(0, 0, 0, 1);
    sb.push_back(pack(2'b01, 0, 0, 0));
    repeat (FPP - 1) cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    repeat (FPP - 1) cyc(1, 1, 0, 0);
    exp_v = sb.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL release_restart got %h exp %h", obs, exp_v); else passed++;
    sb.push_back(pack(2'b01, 1, 0, 0));
    cyc(1, 1, 0, 0);
    exp_v = sb.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL release_8th got %h exp %h", obs, exp_v); else passed++;
  endtask

  task automatic test_bcd_saturate();
    do_reset();
    cyc(0, 0, 0, 1);
    sb.push_back(pack(2'b01, 9, 0, 0));
    play_points(9);
    exp_v = sb.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL bcd_9 got %h exp %h", obs, exp_v); else passed++;
    sb.push_back(pack(2'b01, 10, 0, 0));
    play_points(1);
    exp_v = sb.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL bcd_10 got %h exp %h", obs, exp_v); else passed++;
    sb.push_back(pack(2'b01, 99, 0, 0));
    play_points(89);
    exp_v = sb.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL bcd_99 got %h exp %h", obs, exp_v); else passed++;
    sb.push_back(pack(2'b01, 99, 0, 0));
    play_points(20);
    exp_v = sb.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL saturate got %h exp %h", obs, exp_v); else passed++;
  endtask

  task automatic test_collision();
    do_reset();
    cyc(0, 0, 0, 1);
    play_points(5);
    repeat (FPP - 1) cyc(1, 1, 0, 0);
    sb.push_back(pack(2'b10, 5, 5, 1));
    cyc(1, 1, 1, 0);
    exp_v = sb.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL collide_priority got %h exp %h", obs, exp_v); else passed++;
    sb.push_back(pack(2'b10, 5, 5, 1));
    repeat (3 * FPP) cyc(1, 1, 0, 0);
    exp_v = sb.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL over_frozen got %h exp %h", obs, exp_v); else passed++;
    sb.push_back(pack(2'b01, 0, 5, 0));
    cyc(0, 0, 0, 1);
    exp_v = sb.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL restart got %h exp %h", obs, exp_v); else passed++;
    sb.push_back(pack(2'b01, 0, 5, 0));
    repeat (FPP - 1) cyc(1, 1, 0, 0);
    exp_v = sb.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL hold_cleared got %h exp %h", obs, exp_v); else passed++;
    sb.push_back(pack(2'b10, 5, 5, 0));
    cyc(1, 1, 0, 0);
    play_points(4);
    cyc(0, 0, 1, 0);
    exp_v = sb.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL equal_not_new got %h exp %h", obs, exp_v); else passed++;
    sb.push_back(pack(2'b01, 0, 5, 0));
    cyc(0, 0, 1, 1);
    exp_v = sb.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL start_and_collide got %h exp %h", obs, exp_v); else passed++;
    sb.push_back(pack(2'b01, 1, 5, 0));
    play_points(1);
    cyc(0, 0, 0, 1);
    exp_v = sb.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL start_in_play got %h exp %h", obs, exp_v); else passed++;
  endtask

  task automatic test_async_reset();
    do_reset();
    cyc(0, 0, 0, 1);
    play_points(60);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    sb.push_back(pack(2'b01, 42, 60, 0));
    play_points(42);
    exp_v = sb.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL pre_reset got %h exp %h", obs, exp_v); else passed++;
    sb.push_back(pack(2'b00, 0, 0, 0));
    #2 i_rst_n = 0;
    #1;
    exp_v = sb.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL async_reset got %h exp %h", obs, exp_v); else passed++;
    @(negedge i_clk);
    i_rst_n = 1;
    sb.push_back(pack(2'b00, 0, 0, 0));
    repeat (FPP) cyc(1, 1, 1, 0);
    exp_v = sb.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL idle_after_reset got %h exp %h", obs, exp_v); else passed++;
  endtask

  task automatic test_back_to_back();
    cyc(0, 0, 0, 1);
    sb.push_back(pack(2'b01, 3, 0, 0));
    repeat (3 * FPP) cyc(1, 1, 0, 0);
    exp_v = sb.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL back_to_back got %h exp %h", obs, exp_v); else passed++;
    sb.push_back(pack(2'b10, 3, 3, 1));
    cyc(0, 0, 1, 0);
    exp_v = sb.pop_front(); total++;
    if (obs !== exp_v) $display("FAIL first_high got %h exp %h", obs, exp_v); else passed++;
  endtask

  initial begin
    @(negedge i_clk);
    test_reset();
    test_count();
    test_release();
    test_bcd_saturate();
    test_collision();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset; all state SHALL be held in flops clocked on the rising edge of i_clk.
REQ-002 Parameter FRAMES_PER_POINT, default 8: number of qualifying frame ticks per score point, legal range 1..255.
REQ-003 Parameter MAX_SCORE, default 99: saturation value of the score, legal range 1..99.
REQ-004 i_clk  input  1  pixel clock.
REQ-005 i_rst_n  input  1  asynchronous active-low reset.
REQ-006 i_frame_tick  input  1  single-cycle pulse, once per video frame.
REQ-007 i_move  input  1  move button level, synchronous to i_clk.
REQ-008 i_collision  input  1  player hit detected, level or pulse.
REQ-009 i_start  input  1  start/restart request, level or pulse.
REQ-010 o_score  output  7  current score, binary, 0..MAX_SCORE.
REQ-011 o_score_tens  output  4  BCD tens digit of o_score.
REQ-012 o_score_ones  output  4  BCD ones digit of o_score.
REQ-013 o_high_score  output  7  best score since reset, binary.
REQ-014 o_state  output  2  00 IDLE, 01 PLAY, 10 OVER; 11 never driven.
REQ-015 o_new_high  output  1  high while in OVER if the finished game set a new high score.

Function
REQ-016 All outputs SHALL be registered; no output SHALL depend combinationally on any input.
REQ-017 State machine: IDLE -> PLAY on i_start; PLAY -> OVER on i_collision; OVER -> PLAY on i_start; no other transitions exist.
REQ-018 On entry to PLAY, from IDLE or from OVER, score, BCD digits and hold counter SHALL be 0 in the cycle after i_start is sampled.
REQ-019 In PLAY, a qualifying tick is a cycle with i_frame_tick=1 and i_move=1.
REQ-020 In PLAY, a cycle with i_frame_tick=1 and i_move=0 SHALL clear the hold counter to 0 (release restarts accumulation).
REQ-021 The hold counter SHALL increment on each qualifying tick; on the qualifying tick where it equals FRAMES_PER_POINT-1 it SHALL wrap to 0 and the score SHALL increment by 1 in the same cycle.
REQ-022 Score increment latency: o_score SHALL change on the clock edge that samples the completing qualifying tick (visible the next cycle).
REQ-023 The score SHALL saturate at MAX_SCORE; the hold counter SHALL keep cycling while the score is saturated.
REQ-024 BCD digits SHALL be maintained incrementally without division: ones 9->0 with tens+1; at all times o_score = 10*tens + ones.
REQ-025 i_collision SHALL take priority over an increment in the same PLAY cycle; the score SHALL NOT change in that cycle.
REQ-026 i_start SHALL be ignored in PLAY; i_collision SHALL be ignored in IDLE and OVER.
REQ-027 If i_start and i_collision are both high in IDLE or OVER, the block SHALL enter PLAY.
REQ-028 On the PLAY -> OVER edge, if the final score > o_high_score, o_high_score SHALL load the score and o_new_high SHALL be set; equal scores SHALL NOT set o_new_high.
REQ-029 In OVER, score and digits SHALL be frozen and i_frame_tick/i_move ignored; o_new_high SHALL clear on leaving OVER.
REQ-030 In IDLE, score, digits and hold counter SHALL be held at 0.

Reset
REQ-031 Reset assertion SHALL, asynchronously, force o_state=IDLE and o_score, o_score_tens, o_score_ones, o_high_score, o_new_high and the hold counter to 0, including mid-game.
REQ-032 After reset deassertion, the block SHALL remain in IDLE until i_start is sampled high.

Verification
REQ-033 Reset, i_start, then 16 ticks with i_move=1 (FRAMES_PER_POINT=8) -> o_score=2, tens=0, ones=2.
REQ-034 In PLAY, 7 qualifying ticks, one tick with i_move=0, then 7 qualifying ticks -> o_score stays 0; the 8th consecutive qualifying tick -> o_score=1.
REQ-035 Preload to 9 then complete one point -> o_score=10, tens=1, ones=0; continue to 99 and 20 extra points -> o_score=99, tens=9, ones=9.
REQ-036 i_collision on the same cycle as the 8th qualifying tick with score 5 -> o_state=OVER, o_score=5, o_high_score=5, o_new_high=1.
REQ-037 Next game ends with score 5 -> o_new_high=0, o_high_score=5; i_start in OVER -> o_state=PLAY, o_score=0, o_new_high=0.
REQ-038 i_rst_n driven low mid-game with score 42, high 60 -> all outputs 0 and o_state=IDLE without waiting for a clock edge.
